// File: rtl/prim_clock_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : prim_clock_gate_ctrl_if
// Brief    : Channel-vector bundle between the clock-gate controller and the
//            logic that enables, wakes and observes the gated channels.
// Revision : 1.0 - initial release
// ============================================================================
interface prim_clock_gate_ctrl_if #(
  parameter int NUM_CH     = 4,
  parameter int IDLE_CNT_W = 8
);
  logic                   test_en_i;
  logic [NUM_CH-1:0]      en_i;
  logic [NUM_CH-1:0]      busy_i;
  logic [IDLE_CNT_W-1:0]  idle_thresh_i;
  logic [NUM_CH-1:0]      wake_req_i;
  logic [NUM_CH-1:0]      wake_ack_o;
  logic [NUM_CH-1:0]      gated_o;
  logic [NUM_CH-1:0]      clk_o;
  logic [NUM_CH*16-1:0]   gated_cnt_o;

  // Software / requester side
  modport master (
    output test_en_i, en_i, busy_i, idle_thresh_i, wake_req_i,
    input  wake_ack_o, gated_o, clk_o, gated_cnt_o
  );

  // Controller side
  modport slave (
    input  test_en_i, en_i, busy_i, idle_thresh_i, wake_req_i,
    output wake_ack_o, gated_o, clk_o, gated_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/prim_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prim_clock_gate_ctrl
// Brief    : Multi-channel glitch-free clock-gate controller. Each channel
//            gates itself after a programmable idle period and wakes through
//            a 4-phase req/ack handshake or on busy.
//            Optional gated-cycle statistics: PRIM_CLOCK_GATE_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prim_clock_gate_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  prim_clock_gate_ctrl_if.slave bus
);

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_GATED = 2'd1;
  localparam logic [1:0] c_WAKE  = 2'd2;

  localparam int                    c_WAKE_W    = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [c_WAKE_W-1:0]   c_WAKE_LAST = c_WAKE_W'(WAKE_LAT - 1);
  localparam logic [IDLE_CNT_W-1:0] c_IDLE_MAX  = {IDLE_CNT_W{1'b1}};

  logic [NUM_CH-1:0]    w_clk;
  logic [NUM_CH-1:0]    w_ack;
  logic [NUM_CH-1:0]    w_gated;
  logic [NUM_CH*16-1:0] w_gcnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDLE_CNT_W-1:0] r_idle;
    logic [IDLE_CNT_W-1:0] w_idle_nxt;
    logic [IDLE_CNT_W-1:0] w_idle_cnt;
    logic [c_WAKE_W-1:0]   r_wcnt;
    logic [c_WAKE_W-1:0]   w_wcnt_nxt;
    logic                  r_gated;
    logic                  r_latch_q;
    logic                  w_latch_d;

    // Next-state, idle-counter and wake-latency decisions for this channel
    always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle;
      w_wcnt_nxt  = r_wcnt;
      w_idle_cnt  = '0;
      case (r_state)
        c_RUN: begin
          if (bus.busy_i[i] || bus.wake_req_i[i]) begin
            w_idle_cnt = '0;
          end else if (r_idle == c_IDLE_MAX) begin
            w_idle_cnt = r_idle;
          end else begin
            w_idle_cnt = r_idle + IDLE_CNT_W'(1);
          end
          // Threshold is compared live, so lowering it below the current
          // count gates on the very next edge.
          if (!bus.en_i[i] ||
              ((bus.idle_thresh_i != '0) && (w_idle_cnt >= bus.idle_thresh_i))) begin
            w_state_nxt = c_GATED;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt  = w_idle_cnt;
          end
        end
        c_GATED: begin
          if (bus.en_i[i] && (bus.busy_i[i] || bus.wake_req_i[i])) begin
            w_state_nxt = c_WAKE;
            w_wcnt_nxt  = '0;
          end
        end
        c_WAKE: begin
          if (!bus.en_i[i]) begin
            w_state_nxt = c_GATED;
          end else if (r_wcnt == c_WAKE_LAST) begin
            w_state_nxt = c_RUN;
            w_idle_nxt  = '0;
          end else begin
            w_wcnt_nxt  = r_wcnt + c_WAKE_W'(1);
          end
        end
        default: begin
          w_state_nxt = c_RUN;
          w_idle_nxt  = '0;
        end
      endcase
    end

    // Channel state registers; gated flag registered alongside the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= c_RUN;
        r_idle  <= '0;
        r_wcnt  <= '0;
        r_gated <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_idle  <= w_idle_nxt;
        r_wcnt  <= w_wcnt_nxt;
        r_gated <= (w_state_nxt == c_GATED);
      end
    end

    assign w_latch_d = (r_state != c_GATED) | bus.test_en_i;

    // Enable latch is open only while the root clock is low, so the AND
    // below can never start or cut a high phase. It is deliberately not
    // reset: after reset it picks up the RUN enable in the next low phase.
    always_latch begin
      if (!clk_i) begin
        r_latch_q <= w_latch_d;
      end
    end

    assign w_clk[i]   = clk_i & r_latch_q;
    assign w_ack[i]   = bus.wake_req_i[i] & (r_state == c_RUN);
    assign w_gated[i] = r_gated;

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    logic [15:0] r_gcnt;

    // Saturating count of root-clock cycles spent in GATED
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_gcnt <= '0;
      end else if ((r_state == c_GATED) && (r_gcnt != 16'hFFFF)) begin
        r_gcnt <= r_gcnt + 16'd1;
      end
    end

    assign w_gcnt[i*16 +: 16] = r_gcnt;
`else
    assign w_gcnt[i*16 +: 16] = 16'd0;
`endif
  end

  assign bus.clk_o       = w_clk;
  assign bus.wake_ack_o  = w_ack;
  assign bus.gated_o     = w_gated;
  assign bus.gated_cnt_o = w_gcnt;

endmodule
`default_nettype wire

// File: tb/tb_prim_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_clock_gate_ctrl
// Brief    : Directed self-checking bench for prim_clock_gate_ctrl
//            (idle gating, wake, handshake, test mode, threshold change,
//            statistics, asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_clock_gate_ctrl;

  localparam int c_NUM_CH = 4;
  localparam int c_HALF   = 5;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int snap;

  prim_clock_gate_ctrl_if #(.NUM_CH(c_NUM_CH), .IDLE_CNT_W(8)) bus ();

  prim_clock_gate_ctrl #(
    .NUM_CH     (c_NUM_CH),
    .IDLE_CNT_W (8),
    .WAKE_LAT   (2)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #c_HALF clk = ~clk;

  // Per-channel gated-clock monitors: rising-edge count and high-pulse width
  for (genvar i = 0; i < c_NUM_CH; i++) begin : g_mon
    int  edges = 0;
    int  bad   = 0;
    time t_rise = 0;
    always @(posedge bus.clk_o[i]) begin
      edges  <= edges + 1;
      t_rise <= $time;
    end
    always @(negedge bus.clk_o[i]) begin
      if (($time - t_rise) != c_HALF) bad <= bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.test_en_i     = 1'b0;
    bus.en_i          = 4'hF;
    bus.busy_i        = 4'hF;
    bus.idle_thresh_i = 8'd4;
    bus.wake_req_i    = 4'h0;

    // Reset state
    tick(3);
    check("rst_gated", 32'(bus.gated_o), 32'h0);
    check("rst_ack", 32'(bus.wake_ack_o), 32'h0);
    check("rst_cnt", 32'(bus.gated_cnt_o[31:0]), 32'h0);
    check("rst_clk_follows", 32'(bus.clk_o), 32'hF);
    #5;
    rst_n = 1'b1;
    tick(2);

    // Idle auto-gate: busy drops after an edge, gated after the 4th idle edge
    bus.busy_i[0] = 1'b0;
    tick(3);
    check("idle_not_yet", 32'(bus.gated_o[0]), 32'h0);
    tick(1);
    check("idle_gated", 32'(bus.gated_o[0]), 32'h1);
    check("others_run", 32'(bus.gated_o[3:1]), 32'h0);
    snap = g_mon[0].edges;
    tick(5);
    check("gated_no_edges", 32'(g_mon[0].edges), 32'(snap));

    // Wake on busy: gated_o falls on the edge, clock resumes on the next
    bus.busy_i[0] = 1'b1;
    tick(1);
    check("wake_busy_gated0", 32'(bus.gated_o[0]), 32'h0);
    snap = g_mon[0].edges;
    tick(1);
    check("wake_clk_resume", 32'(g_mon[0].edges), 32'(snap + 1));
    tick(1);
    check("wake_busy_noack", 32'(bus.wake_ack_o[0]), 32'h0);

    // Wake by request: ack two cycles after WAKE entry, held while req held
    bus.busy_i[0] = 1'b0;
    tick(4);
    check("regate", 32'(bus.gated_o[0]), 32'h1);
    bus.wake_req_i[0] = 1'b1;
    tick(1);
    check("req_wake_gated0", 32'(bus.gated_o[0]), 32'h0);
    check("req_ack_wake1", 32'(bus.wake_ack_o[0]), 32'h0);
    tick(1);
    check("req_ack_wake2", 32'(bus.wake_ack_o[0]), 32'h0);
    tick(1);
    check("req_ack_run", 32'(bus.wake_ack_o[0]), 32'h1);
    tick(6);
    check("req_hold_nogate", 32'(bus.gated_o[0]), 32'h0);
    check("req_hold_ack", 32'(bus.wake_ack_o[0]), 32'h1);
    bus.wake_req_i[0] = 1'b0;
    #1;
    check("req_drop_ack0", 32'(bus.wake_ack_o[0]), 32'h0);
    tick(3);
    check("req_drop_idle3", 32'(bus.gated_o[0]), 32'h0);
    tick(1);
    check("req_drop_gated", 32'(bus.gated_o[0]), 32'h1);

    // Test mode while gated, toggled at odd clock phases
    #2;
    bus.test_en_i = 1'b1;
    snap = g_mon[0].edges;
    tick(4);
    check("test_edges", 32'(g_mon[0].edges), 32'(snap + 4));
    check("test_clk_high", 32'(bus.clk_o[0]), 32'h1);
    check("test_gated_kept", 32'(bus.gated_o[0]), 32'h1);
    #6;
    bus.test_en_i = 1'b0;
    snap = g_mon[0].edges;
    tick(3);
    check("test_off_noedge", 32'(g_mon[0].edges), 32'(snap));

    // en_i=0 wins over simultaneous busy and wake request
    bus.en_i[1]       = 1'b0;
    bus.wake_req_i[1] = 1'b1;
    tick(1);
    check("en0_gated", 32'(bus.gated_o[1]), 32'h1);
    check("en0_noack", 32'(bus.wake_ack_o[1]), 32'h0);
    tick(3);
    check("en0_stay", 32'(bus.gated_o[1]), 32'h1);
    check("en0_noack_late", 32'(bus.wake_ack_o[1]), 32'h0);
    bus.wake_req_i[1] = 1'b0;
    bus.en_i[1]       = 1'b1;
    tick(3);
    check("en1_rewake", 32'(bus.gated_o[1]), 32'h0);

    // Threshold lowered below current idle count gates on the next edge
    bus.idle_thresh_i = 8'd200;
    bus.busy_i[2]     = 1'b0;
    tick(6);
    check("thr_hi_run", 32'(bus.gated_o[2]), 32'h0);
    bus.idle_thresh_i = 8'd3;
    tick(1);
    check("thr_lo_gate", 32'(bus.gated_o[2]), 32'h1);

    // Threshold 0 disables auto-gating
    bus.idle_thresh_i = 8'd0;
    bus.busy_i[3]     = 1'b0;
    tick(10);
    check("thr0_nogate", 32'(bus.gated_o[3]), 32'h0);
    bus.busy_i[3]     = 1'b1;
    bus.idle_thresh_i = 8'd4;
    tick(1);

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    tick(70000);
    check("stats_sat", 32'(bus.gated_cnt_o[15:0]), 32'hFFFF);
`else
    check("stats_off", 32'(bus.gated_cnt_o[31:0]), 32'h0);
`endif

    // Asynchronous reset in WAKE: every channel back in RUN (acks follow req)
    bus.busy_i[0] = 1'b1;
    tick(1);
    check("pre_rst_wake", 32'(bus.gated_o[0]), 32'h0);
    rst_n          = 1'b0;
    bus.wake_req_i = 4'hF;
    #1;
    check("arst_all_run", 32'(bus.wake_ack_o), 32'hF);
    check("arst_gated0", 32'(bus.gated_o), 32'h0);
    check("arst_cnt0", 32'(bus.gated_cnt_o[31:0]), 32'h0);
    tick(2);
    rst_n          = 1'b1;
    bus.wake_req_i = 4'h0;
    tick(2);

    for (int i = 0; i < c_NUM_CH; i++) begin
      case (i)
        0: check("pulse_ch0", 32'(g_mon[0].bad), 32'h0);
        1: check("pulse_ch1", 32'(g_mon[1].bad), 32'h0);
        2: check("pulse_ch2", 32'(g_mon[2].bad), 32'h0);
        default: check("pulse_ch3", 32'(g_mon[3].bad), 32'h0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
